// File: rtl/atmega_clkgen.sv
// atmega_clkgen: PLL-gated multi-channel integer+fractional clock-enable generator
module atmega_clkgen #(
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int CSR_ADDR = 'h49,
  parameter int DIV_BASE_ADDR = 'h52,
  parameter int CHANNELS = 2,
  parameter int DIV_WIDTH = 8,
  parameter int FRAC_WIDTH = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic [CHANNELS-1:0]          ck_en,
  output logic [CHANNELS-1:0]          ck_out,
  output logic                         locked
);
  localparam int LW = $clog2(LOCK_CYCLES) + 1;
  logic                  plle;
  logic                  plock;
  logic [CHANNELS-1:0]   chen;
  logic [LW-1:0]         lcnt;
  logic [DIV_WIDTH-1:0]  divi [CHANNELS];
  logic [FRAC_WIDTH-1:0] divf [CHANNELS];
  logic                  csr_sel;
  logic                  unused_ok;
  assign csr_sel   = addr == BUS_ADDR_DATA_LEN'(CSR_ADDR);
  assign locked    = plock;
  assign unused_ok = ^bus_in;
  // control register and per-channel shadow divider registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      plle <= 1'b0;
      chen <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        divi[c] <= '0;
        divf[c] <= '0;
      end
    end else if (wr) begin
      if (csr_sel) begin
        plle <= bus_in[1];
        chen <= bus_in[4 +: CHANNELS];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (addr == BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2*c)) divi[c] <= bus_in[DIV_WIDTH-1:0];
        if (addr == BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2*c + 1)) divf[c] <= bus_in[FRAC_WIDTH-1:0];
      end
    end
  // lock delay: count while enabled and unlocked, hold lock until PLLE drops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lcnt  <= '0;
      plock <= 1'b0;
    end else if (!plle) begin
      lcnt  <= '0;
      plock <= 1'b0;
    end else if (!plock) begin
      if (lcnt == LW'(LOCK_CYCLES - 1)) plock <= 1'b1;
      else lcnt <= lcnt + LW'(1);
    end
  // combinational read mux, silent when not reading or in reset
  always_comb begin
    bus_out = '0;
    if (!rst && rd) begin
      if (csr_sel) begin
        bus_out[0]              = plock;
        bus_out[1]              = plle;
        bus_out[4 +: CHANNELS]  = chen;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (addr == BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2*c)) bus_out = 8'(divi[c]);
        if (addr == BUS_ADDR_DATA_LEN'(DIV_BASE_ADDR + 2*c + 1)) bus_out = 8'(divf[c]);
      end
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH:0]  cnt;
    logic [FRAC_WIDTH-1:0] acc;
    logic [FRAC_WIDTH:0] sum;
    logic                run;
    logic                en;
    logic                tog;
    assign run      = plock & plle & chen[i];
    assign sum      = {1'b0, acc} + {1'b0, divf[i]};
    assign ck_en[i]  = en;
    assign ck_out[i] = tog;
    // divider: idle tracks the shadow N; at each boundary reload N plus fractional carry
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        acc <= '0;
        en  <= 1'b0;
        tog <= 1'b0;
      end else if (!run) begin
        cnt <= {1'b0, divi[i]};
        acc <= '0;
        en  <= 1'b0;
        tog <= 1'b0;
      end else if (cnt == '0) begin
        cnt <= {1'b0, divi[i]} + {{DIV_WIDTH{1'b0}}, sum[FRAC_WIDTH]};
        acc <= sum[FRAC_WIDTH-1:0];
        en  <= 1'b1;
        tog <= ~tog;
      end else begin
        cnt <= cnt - (DIV_WIDTH+1)'(1);
        en  <= 1'b0;
      end
  end
endmodule

// File: tb/tb_atmega_clkgen.sv
// tb_atmega_clkgen: randomized bench against an event-scheduled reference model
module tb_atmega_clkgen;
  localparam int CH = 2, DW = 8, FW = 4, L = 64, CSR = 'h49, BASE = 'h52;
  logic rst, clk, wr, rd;
  logic [15:0] addr;
  logic [7:0] bus_in, bus_out;
  logic [CH-1:0] ck_en, ck_out;
  logic locked;
  int n_cmp, n_err;
  int m_k, m_since, m_chen;
  bit m_plle, m_locked;
  int m_divi[4], m_divf[4], m_dpre[4], m_next[4], m_acc[4];
  bit m_started[4], m_en[4], m_out[4];

  atmega_clkgen #(.BUS_ADDR_DATA_LEN(16), .CSR_ADDR(CSR), .DIV_BASE_ADDR(BASE), .CHANNELS(CH),
                  .DIV_WIDTH(DW), .FRAC_WIDTH(FW), .LOCK_CYCLES(L)) dut (
    .rst(rst), .clk(clk), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bus_out), .ck_en(ck_en), .ck_out(ck_out), .locked(locked));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_since = 0; m_chen = 0; m_plle = 0; m_locked = 0;
    for (int c = 0; c < 4; c++) begin
      m_divi[c] = 0; m_divf[c] = 0; m_dpre[c] = 0; m_next[c] = 0; m_acc[c] = 0;
      m_started[c] = 0; m_en[c] = 0; m_out[c] = 0;
    end
  endtask

  function automatic logic [7:0] exp_bus(input logic r, input logic [15:0] a);
    if (!r) return 8'h00;
    if (a == 16'(CSR)) return 8'((m_chen << 4) | (int'(m_plle) << 1) | int'(m_locked));
    for (int c = 0; c < CH; c++) begin
      if (a == 16'(BASE + 2*c)) return 8'(m_divi[c]);
      if (a == 16'(BASE + 2*c + 1)) return 8'(m_divf[c]);
    end
    return 8'h00;
  endfunction

  // advance the model by one clock edge using the values held before that edge
  task automatic model_step(input logic w, input logic [15:0] a, input logic [7:0] d);
    int k, s;
    bit nl;
    m_k++;
    k = m_k;
    for (int c = 0; c < CH; c++) begin
      if (!(m_locked && m_plle && m_chen[c])) begin
        m_started[c] = 0; m_en[c] = 0; m_out[c] = 0; m_acc[c] = 0;
      end else begin
        if (!m_started[c]) begin
          m_started[c] = 1;
          m_next[c] = k + m_dpre[c];
        end
        if (k == m_next[c]) begin
          s = m_acc[c] + m_divf[c];
          m_acc[c] = s % (1 << FW);
          m_next[c] = k + m_divi[c] + 1 + s / (1 << FW);
          m_en[c] = 1;
          m_out[c] = !m_out[c];
        end else m_en[c] = 0;
      end
    end
    nl = m_plle && (m_locked || (k - m_since >= L));
    for (int c = 0; c < CH; c++) m_dpre[c] = m_divi[c];
    if (w) begin
      if (a == 16'(CSR)) begin
        if (d[1] && !m_plle) m_since = k;
        m_plle = d[1];
        m_chen = (int'(d) >> 4) & ((1 << CH) - 1);
      end
      for (int c = 0; c < CH; c++) begin
        if (a == 16'(BASE + 2*c)) m_divi[c] = int'(d) & ((1 << DW) - 1);
        if (a == 16'(BASE + 2*c + 1)) m_divf[c] = int'(d) & ((1 << FW) - 1);
      end
    end
    m_locked = nl;
  endtask

  task automatic cycle(input logic w, input logic [15:0] a, input logic [7:0] d, input logic r);
    wr = w; addr = a; bus_in = d; rd = r;
    #1;
    check("bus_out", bus_out, exp_bus(r, a));
    model_step(w, a, d);
    @(posedge clk);
    #1;
    wr = 0; rd = 0;
    check("locked", locked, m_locked);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("ck_en%0d", c), ck_en[c], m_en[c]);
      check($sformatf("ck_out%0d", c), ck_out[c], m_out[c]);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return 16'(CSR);
      1: return 16'(BASE + $urandom_range(0, 7));
      2: return 16'($urandom);
      default: return 16'(CSR + 1);
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, rand_addr(), 8'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    logic [7:0] d;
    int p;
    n_cmp = 0; n_err = 0;
    rst = 1; wr = 0; rd = 1; addr = 16'(CSR); bus_in = 0;
    model_reset();
    #12;
    check("rst_ck_en", ck_en, 0);
    check("rst_ck_out", ck_out, 0);
    check("rst_locked", locked, 0);
    check("rst_bus_out", bus_out, 0);
    #1 rst = 0;
    cycle(1'b1, 16'(BASE), 8'd3, 1'b0);
    cycle(1'b1, 16'(BASE + 1), 8'd0, 1'b0);
    cycle(1'b1, 16'(CSR), 8'h32, 1'b1);
    idle(150);
    cycle(1'b1, 16'(BASE), 8'd7, 1'b1);
    idle(60);
    cycle(1'b1, 16'(BASE), 8'd2, 1'b0);
    cycle(1'b1, 16'(BASE + 1), 8'd8, 1'b0);
    idle(60);
    cycle(1'b1, 16'(CSR), 8'h10, 1'b1);
    idle(10);
    cycle(1'b1, 16'(CSR), 8'hF3, 1'b1);
    idle(90);
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 199);
      if (p == 0) begin
        d = 8'($urandom);
        d[1] = ($urandom_range(0, 9) != 0);
        cycle(1'b1, 16'(CSR), d, 1'($urandom_range(0, 1)));
      end else if (p < 10) begin
        d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
        cycle(1'b1, 16'(BASE + $urandom_range(0, 2*CH - 1)), d, 1'($urandom_range(0, 1)));
      end else if (p < 12) cycle(1'b1, rand_addr(), 8'($urandom), 1'($urandom_range(0, 1)));
      else idle(1);
    end
    cycle(1'b1, 16'(BASE), 8'd0, 1'b0);
    cycle(1'b1, 16'(BASE + 1), 8'd0, 1'b0);
    cycle(1'b1, 16'(CSR), 8'h32, 1'b0);
    idle(80);
    #2 rst = 1; rd = 1; addr = 16'(CSR);
    #1;
    check("arst_ck_en", ck_en, 0);
    check("arst_ck_out", ck_out, 0);
    check("arst_locked", locked, 0);
    check("arst_bus_out", bus_out, 0);
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    idle(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
